// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two sram-like masters (inst, data) share one sram-like
// slave. Data has priority, but an inst requester that has watched
// STARVE_LIM consecutive data grants wins the next grant. Accepted
// transactions are tracked in an owner FIFO so that responses, which return
// in order, are routed back to the master that issued them.
module sram_like_arbiter #(
    parameter int OUT_DEPTH  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // inst-side master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    // data-side master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    // downstream slave
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    // sticky protocol error: response with nothing outstanding
    output logic        err
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_LIM + 1);

    // A request the slave has not yet accepted keeps the bus for its owner.
    typedef enum logic {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e       lock_state_q;
    logic              lock_owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [OUT_DEPTH-1:0] owner_q;
    logic [ST_W-1:0]   starve_cnt_q;
    logic              err_q;

    logic full;
    logic sel_valid;
    logic sel_data;
    logic push;
    logic pop;
    logic head_owner;

    assign full = (cnt_q == CNT_W'(OUT_DEPTH));

    // Pick the requester: lock owner first, then starvation relief, then data priority.
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 1'b0;
        if (lock_state_q == S_LOCKED) begin
            sel_data  = lock_owner_q;
            sel_valid = lock_owner_q ? data_req : inst_req;
        end else if (inst_req && (starve_cnt_q == ST_W'(STARVE_LIM))) begin
            sel_valid = 1'b1;
            sel_data  = 1'b0;
        end else if (data_req) begin
            sel_valid = 1'b1;
            sel_data  = 1'b1;
        end else if (inst_req) begin
            sel_valid = 1'b1;
            sel_data  = 1'b0;
        end
    end

    // resetn gates the request so it drops without waiting for a clock edge.
    assign m_req = resetn & sel_valid & ~full;

    // Route the selected master's command fields to the slave.
    always_comb begin
        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        if (m_req) begin
            m_wr    = sel_data ? data_wr    : inst_wr;
            m_size  = sel_data ? data_size  : inst_size;
            m_addr  = sel_data ? data_addr  : inst_addr;
            m_wdata = sel_data ? data_wdata : inst_wdata;
        end
    end

    assign push         = m_req & m_addr_ok;
    assign inst_addr_ok = push & ~sel_data;
    assign data_addr_ok = push &  sel_data;

    // Responses pop the oldest owner; cnt_q is cleared asynchronously, so data_ok
    // is already 0 while in reset.
    assign pop          = m_data_ok & (cnt_q != '0);
    assign head_owner   = owner_q[head_q];
    assign inst_data_ok = pop & ~head_owner;
    assign data_data_ok = pop &  head_owner;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;
    assign err        = err_q;

    // Lock FSM: hold the selection while the slave stalls a presented request.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state_q <= S_OPEN;
            lock_owner_q <= 1'b0;
        end else if (m_req && !m_addr_ok) begin
            lock_state_q <= S_LOCKED;
            lock_owner_q <= sel_data;
        end else if (push) begin
            lock_state_q <= S_OPEN;
        end
    end

    // Outstanding count and FIFO pointers; a simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Owner storage at the tail on each accepted request.
    // NOTE: storage is not reset; an entry is only read while cnt_q says it is valid.
    always_ff @(posedge clk) begin
        if (push) owner_q[tail_q] <= sel_data;
    end

    // Count data grants that overtook a waiting inst request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
        end else if (!inst_req || (push && !sel_data)) begin
            starve_cnt_q <= '0;
        end else if (push && sel_data && (starve_cnt_q != ST_W'(STARVE_LIM))) begin
            starve_cnt_q <= starve_cnt_q + ST_W'(1);
        end
    end

    // Sticky error for a response with no transaction outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (m_data_ok && (cnt_q == '0)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (OUT_DEPTH=2, STARVE_LIM=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata, m_rdata, m_addr, m_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, err;

    int checks   = 0;
    int failures = 0;

    sram_like_arbiter #(.OUT_DEPTH(2), .STARVE_LIM(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
    endtask

    // Outputs are forced low while in reset, even with every input active.
    task automatic test_reset();
        resetn = 0;
        set_idle();
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #1;
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req got=%0b exp=0", m_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        @(negedge clk);
        set_idle();
        resetn = 1;
    endtask

    // Both masters request every cycle: four data grants, then inst, then data.
    task automatic test_starvation();
        bit exp_data [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inst_req = 1; data_req = 1;
            inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
            m_addr_ok = 1; m_data_ok = (i > 0);
            #1;
            checks++;
            if (m_addr !== (exp_data[i] ? 32'h0000_2000 : 32'h0000_1000)) begin
                failures++; $display("FAIL starve_grant[%0d] m_addr got=%h exp_data_side=%0b", i, m_addr, exp_data[i]);
            end
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {~exp_data[i], exp_data[i]}) begin
                failures++; $display("FAIL starve_addr_ok[%0d] got=%b exp=%b", i, {inst_addr_ok, data_addr_ok}, {~exp_data[i], exp_data[i]});
            end
            if (i > 0) begin
                checks++;
                if ({inst_data_ok, data_data_ok} !== {~exp_data[i-1], exp_data[i-1]}) begin
                    failures++; $display("FAIL starve_data_ok[%0d] got=%b exp=%b", i, {inst_data_ok, data_data_ok}, {~exp_data[i-1], exp_data[i-1]});
                end
            end
        end
        @(negedge clk);
        set_idle();
        m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL starve_drain got=%b exp=01", {inst_data_ok, data_data_ok}); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL starve_drain_m_req got=%0b exp=0", m_req); end
    endtask

    // Stalled inst request keeps the bus; then fill to OUT_DEPTH and release one slot.
    task automatic test_lock_and_full();
        // cycles 0..2: slave stalls inst, data arrives at cycle 2
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_idle();
            inst_req = 1; inst_wr = 1; inst_size = 2'd2;
            inst_addr = 32'h0000_00A0; inst_wdata = 32'h1111_2222;
            data_req = (c == 2); data_addr = 32'h0000_00D0;
            #1;
            checks++; if (m_addr !== 32'h0000_00A0) begin failures++; $display("FAIL lock_hold[%0d] m_addr got=%h exp=000000a0", c, m_addr); end
            checks++; if ({m_req, inst_addr_ok, data_addr_ok} !== 3'b100) begin failures++; $display("FAIL lock_stall[%0d] req/iok/dok got=%b exp=100", c, {m_req, inst_addr_ok, data_addr_ok}); end
        end
        checks++; if ({m_wr, m_size, m_wdata} !== {1'b1, 2'd2, 32'h1111_2222}) begin failures++; $display("FAIL lock_fields got=%b/%0d/%h exp=1/2/11112222", m_wr, m_size, m_wdata); end
        // cycle 3: slave accepts inst despite data waiting
        @(negedge clk);
        m_addr_ok = 1;
        #1;
        checks++; if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'h0000_00A0, 2'b10}) begin failures++; $display("FAIL lock_accept got=%h/%b exp=000000a0/10", m_addr, {inst_addr_ok, data_addr_ok}); end
        // cycle 4: data granted next
        @(negedge clk);
        inst_req = 0;
        #1;
        checks++; if ({m_addr, data_addr_ok} !== {32'h0000_00D0, 1'b1}) begin failures++; $display("FAIL lock_next_data got=%h/%b exp=000000d0/1", m_addr, data_addr_ok); end
        // cycle 5: two outstanding -> full
        @(negedge clk);
        inst_req = 1;
        #1;
        checks++; if ({m_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin failures++; $display("FAIL full_block got=%b exp=000", {m_req, inst_addr_ok, data_addr_ok}); end
        // cycle 6: response pops the inst entry; full still from registered count
        @(negedge clk);
        m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL full_pop_route got=%b exp=10", {inst_data_ok, data_data_ok}); end
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%0b exp=0", m_req); end
        // cycle 7: slot freed, data wins
        @(negedge clk);
        m_data_ok = 0;
        #1;
        checks++; if ({m_req, m_addr, data_addr_ok} !== {1'b1, 32'h0000_00D0, 1'b1}) begin failures++; $display("FAIL full_resume got=%b/%h/%b exp=1/000000d0/1", m_req, m_addr, data_addr_ok); end
        // cycles 8..9: drain two data responses
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_idle();
            m_data_ok = 1;
            #1;
            checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL full_drain[%0d] got=%b exp=01", c, {inst_data_ok, data_data_ok}); end
        end
    endtask

    // Pop of an inst entry and push of a data entry in the same cycle at cnt=1.
    task automatic test_back_to_back();
        @(negedge clk);
        set_idle();
        inst_req = 1; m_addr_ok = 1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL b2b_push_inst got=%0b exp=1", inst_addr_ok); end
        @(negedge clk);
        inst_req = 0; data_req = 1; m_data_ok = 1; m_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if ({inst_data_ok, data_data_ok, data_addr_ok} !== 3'b101) begin failures++; $display("FAIL b2b_same_cycle got=%b exp=101", {inst_data_ok, data_data_ok, data_addr_ok}); end
        checks++; if ({inst_rdata, data_rdata} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin failures++; $display("FAIL b2b_rdata got=%h/%h exp=cafef00d", inst_rdata, data_rdata); end
        @(negedge clk);
        data_req = 0; m_addr_ok = 0;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL b2b_next_route got=%b exp=01", {inst_data_ok, data_data_ok}); end
    endtask

    // Response with nothing outstanding sets the sticky error; reset clears it.
    task automatic test_err();
        @(negedge clk);
        set_idle();
        m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok, err} !== 3'b000) begin failures++; $display("FAIL err_no_pulse got=%b exp=000", {inst_data_ok, data_data_ok, err}); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            m_data_ok = 0;
            #1;
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky[%0d] got=%0b exp=1", c, err); end
        end
        @(negedge clk);
        resetn = 0;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", err); end
        @(negedge clk);
        resetn = 1;
    endtask

    // Reset mid-transfer with two outstanding: outputs drop between edges, count clears.
    task automatic test_async_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_idle();
            inst_req = 1; data_req = 1; m_addr_ok = 1;
            #1;
            checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL arst_fill[%0d] got=%0b exp=1", c, data_addr_ok); end
        end
        @(negedge clk);
        m_data_ok = 1;
        #1;
        checks++; if ({m_req, data_data_ok} !== 2'b01) begin failures++; $display("FAIL arst_pre got=%b exp=01", {m_req, data_data_ok}); end
        #2;
        resetn = 0;
        #1;
        checks++; if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err} !== 6'b0) begin
            failures++; $display("FAIL arst_async got=%b exp=000000", {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err});
        end
        @(negedge clk);
        set_idle();
        resetn = 1;
        @(negedge clk);
        data_req = 1; m_data_ok = 1;
        #1;
        checks++; if ({m_req, inst_data_ok, data_data_ok} !== 3'b100) begin failures++; $display("FAIL arst_empty got=%b exp=100", {m_req, inst_data_ok, data_data_ok}); end
        @(negedge clk);
        set_idle();
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL arst_err_after got=%0b exp=1", err); end
        resetn = 0;
        @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_lock_and_full();
        test_back_to_back();
        test_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2, setting the maximum number of accepted-but-unanswered transactions (power of 2, 2..8).
REQ-002 SHALL have parameter STARVE_LIM, default 4, setting the maximum number of consecutive data grants while inst is waiting.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have inst-side ports inst_req in 1, inst_wr in 1, inst_size in 2, inst_addr in 32, inst_wdata in 32, inst_rdata out 32, inst_addr_ok out 1, inst_data_ok out 1 (sram-like master).
REQ-006 SHALL have data-side ports data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok, with the same widths and directions as the inst side.
REQ-007 SHALL have downstream ports m_req out 1, m_wr out 1, m_size out 2, m_addr out 32, m_wdata out 32, m_rdata in 32, m_addr_ok in 1, m_data_ok in 1 (sram-like slave side).
REQ-008 SHALL have port err  output  1  sticky flag for a response arriving with no transaction outstanding.

Function
REQ-009 SHALL track an outstanding count cnt (0..OUT_DEPTH) and an owner FIFO of depth OUT_DEPTH (1 bit per entry: 1=data, 0=inst).
REQ-010 SHALL compute full = (cnt == OUT_DEPTH); while full, m_req = 0 and both addr_ok outputs = 0.
REQ-011 SHALL, when not full and unlocked, select data if data_req, else inst if inst_req, except that inst is selected when inst_req=1 and starve_cnt == STARVE_LIM.
REQ-012 SHALL drive m_req = 1 whenever a selection exists and not full, and pass the selected side's wr/size/addr/wdata combinationally to m_*.
REQ-013 SHALL, when m_req=1 and m_addr_ok=0, register lock=1 and lock_owner=selection; while locked, the selection SHALL equal lock_owner regardless of the other requester.
REQ-014 SHALL clear lock on the cycle m_req & m_addr_ok is sampled.
REQ-015 SHALL drive addr_ok = m_addr_ok & m_req & (selection == that side) and 0 to the other side.
REQ-016 SHALL, on handshake (m_req & m_addr_ok), push the owner bit to the FIFO tail.
REQ-017 SHALL, on m_data_ok with cnt > 0, pop the FIFO head and assert data_ok only to the head's owner in that same cycle (zero-latency combinational route).
REQ-018 SHALL broadcast m_rdata unmodified to both inst_rdata and data_rdata.
REQ-019 SHALL handle push and pop in the same cycle with cnt unchanged, head/tail pointers both advancing modulo OUT_DEPTH; the head SHALL be popped before the tail is written when cnt == 0 is impossible (pop requires cnt > 0).
REQ-020 SHALL allow a push in the same cycle as a pop when cnt == OUT_DEPTH only if full is re-evaluated from the registered cnt (no bypass): m_req stays 0 that cycle.
REQ-021 SHALL, on m_data_ok with cnt == 0, assert neither data_ok output, leave the FIFO unchanged, and set err=1 until reset.
REQ-022 SHALL increment starve_cnt (saturating at STARVE_LIM) on each data handshake while inst_req=1, and clear it on any inst handshake or any cycle with inst_req=0.
REQ-023 SHALL preserve in-order response routing: responses return to owners in handshake order.

Reset
REQ-024 SHALL, while resetn=0, force cnt=0, FIFO pointers=0, lock=0, lock_owner=0, starve_cnt=0, err=0; hence m_req, all addr_ok and data_ok outputs = 0 immediately (asynchronously).
REQ-025 SHALL discard all outstanding transactions on reset mid-operation; responses arriving after deassertion with cnt==0 follow REQ-021.
REQ-026 SHALL resume arbitration on the first rising edge after resetn deasserts.

Verification
REQ-027 Both req=1, m_addr_ok=1 every cycle, m_data_ok 1 cycle after each handshake -> grants D,D,D,D,I,D...; data_ok routed matching grant order.
REQ-028 inst_req alone, m_addr_ok=0 for 3 cycles, then data_req rises at cycle 2 -> m_addr stays inst_addr until handshake at cycle 3; data granted next.
REQ-029 OUT_DEPTH=2, two handshakes with no m_data_ok -> m_req=0, addr_ok=0; one m_data_ok with a pending req -> m_req=1 next cycle.
REQ-030 m_data_ok with cnt=0 -> no data_ok pulse, err=1 sticky; then reset -> err=0.
REQ-031 Same-cycle pop (owner=inst) and push (data) at cnt=1 -> inst_data_ok=1, cnt stays 1, next response routed to data.
REQ-032 resetn asserted low with cnt=2 mid-transfer -> all outputs 0 without waiting for a clock edge, cnt=0 after release.
